// File: rtl/imem_byte_loader.sv
// imem_byte_loader: packs a UART byte stream into 32-bit words (MSB first)
// and writes them bottom-up into instruction memory until halt or full.
module imem_byte_loader #(
  parameter int          NB_DATA   = 32,
  parameter int          NB_ADDR   = 8,
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  output logic               o_we,
  output logic [NB_DATA-1:0] o_data,
  output logic [NB_ADDR-1:0] o_addr,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_overflow,
  output logic [NB_ADDR-2:0] o_word_count
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE
  } state_t;

  // Base of the topmost word slot; writing it fills memory.
  localparam logic [NB_ADDR-1:0] LAST_BASE = {{(NB_ADDR-2){1'b1}}, 2'b00};
  localparam logic [NB_ADDR-1:0] WORD_STEP = NB_ADDR'(4);

  state_t state_q;
  state_t state_d;

  logic [1:0]         cnt_q;
  logic [1:0]         cnt_d;
  logic [NB_DATA-1:0] asm_q;
  logic [NB_DATA-1:0] asm_d;
  logic [NB_DATA-1:0] data_q;
  logic [NB_DATA-1:0] data_d;
  logic [NB_ADDR-1:0] base_q;
  logic [NB_ADDR-1:0] base_d;
  logic [NB_ADDR-1:0] addr_q;
  logic [NB_ADDR-1:0] addr_d;
  logic [NB_ADDR-2:0] wcnt_q;
  logic [NB_ADDR-2:0] wcnt_d;
  logic               ovf_q;
  logic               ovf_d;
  logic               take;
  logic               restart;

  // Next-state, byte capture and word bookkeeping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    data_d  = data_q;
    base_d  = base_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    ovf_d   = ovf_q;
    take    = 1'b0;
    restart = 1'b0;

    unique case (state_q)
      IDLE: begin
        restart = i_start;
      end
      COLLECT: begin
        take = i_rx_valid;
      end
      WRITE: begin
        wcnt_d = wcnt_q + 1'b1;
        base_d = base_q + WORD_STEP;
        if (data_q == HALT_WORD) begin
          state_d = DONE;
          ovf_d   = 1'b0;
        end else if (base_q == LAST_BASE) begin
          state_d = DONE;
          ovf_d   = 1'b1;
        end else begin
          // A byte landing here opens the next word.
          state_d = COLLECT;
          take    = i_rx_valid;
        end
      end
      DONE: begin
        restart = i_start;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (restart) begin
      state_d = COLLECT;
      cnt_d   = 2'd0;
      base_d  = '0;
      wcnt_d  = '0;
      ovf_d   = 1'b0;
    end

    if (take) begin
      // Lane 3 - cnt: first byte lands in the top byte.
      asm_d[{~cnt_q, 3'b000} +: 8] = i_rx_data;
      cnt_d = cnt_q + 2'd1;
      if (cnt_q == 2'd3) begin
        state_d = WRITE;
        data_d  = {asm_q[NB_DATA-1:8], i_rx_data};
        addr_d  = base_q + WORD_STEP;
      end
    end
  end

  // State and datapath registers; reset drops any partial word.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      asm_q   <= '0;
      data_q  <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      wcnt_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      data_q  <= data_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_we         = (state_q == WRITE);
  assign o_busy       = (state_q == COLLECT) || (state_q == WRITE);
  assign o_done       = (state_q == DONE);
  assign o_data       = data_q;
  assign o_addr       = addr_q;
  assign o_overflow   = ovf_q;
  assign o_word_count = wcnt_q;

endmodule

// File: tb/tb_imem_byte_loader.sv
// tb_imem_byte_loader: random and directed byte streams against a
// word-level load model; writes checked through a scoreboard queue.
module tb_imem_byte_loader;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_we;
  logic [31:0] o_data;
  logic [7:0]  o_addr;
  logic        o_busy;
  logic        o_done;
  logic        o_overflow;
  logic [6:0]  o_word_count;

  always #5 clk = ~clk;

  imem_byte_loader dut (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .o_we         (o_we),
    .o_data       (o_data),
    .o_addr       (o_addr),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_overflow   (o_overflow),
    .o_word_count (o_word_count)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  addr;
    logic [6:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Load model: a load is a list of words; memory holds 64 words.
  logic        m_loading = 1'b0;
  logic        m_hold    = 1'b0;
  int          m_n       = 0;
  int          m_nb      = 0;
  logic [31:0] m_acc     = '0;
  logic        m_done    = 1'b0;
  logic        m_ovf     = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_loading = 1'b0;
    m_hold    = 1'b0;
    m_n       = 0;
    m_nb      = 0;
    m_done    = 1'b0;
    m_ovf     = 1'b0;
  endtask

  // One cycle of input seen by the model.
  task automatic model(input logic s, input logic v, input logic [7:0] b);
    exp_t e;
    if (m_hold) begin
      // cycle in which the final word is being written
      m_hold = 1'b0;
    end else if (!m_loading) begin
      if (s) begin
        m_loading = 1'b1;
        m_n       = 0;
        m_nb      = 0;
        m_done    = 1'b0;
        m_ovf     = 1'b0;
      end
    end else if (v) begin
      m_acc = {m_acc[23:0], b};
      m_nb++;
      if (m_nb == 4) begin
        e.data = m_acc;
        e.addr = 8'((m_n + 1) * 4);
        e.cnt  = 7'(m_n);
        sb.push_back(e);
        m_n++;
        m_nb = 0;
        if (m_acc == 32'hFFFFFFFF || m_n == 64) begin
          m_loading = 1'b0;
          m_hold    = 1'b1;
          m_done    = 1'b1;
          m_ovf     = (m_acc != 32'hFFFFFFFF);
        end
      end
    end
  endtask

  task automatic step(input logic s, input logic v, input logic [7:0] b);
    i_start    = s;
    i_rx_valid = v;
    i_rx_data  = b;
    model(s, v, b);
    @(posedge clk);
    #1;
    i_start    = 1'b0;
    i_rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, w[31-8*i -: 8]);
      if (gap > 0) idle($urandom_range(0, gap));
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == 32'hFFFFFFFF) w = 32'h0;
    return w;
  endfunction

  task automatic status(input string tag);
    @(negedge clk);
    chk({tag, "_busy"},  {31'b0, o_busy},       {31'b0, m_loading});
    chk({tag, "_done"},  {31'b0, o_done},       {31'b0, m_done});
    chk({tag, "_count"}, {25'b0, o_word_count}, 32'(m_n));
    if (m_done) chk({tag, "_ovf"}, {31'b0, o_overflow}, {31'b0, m_ovf});
  endtask

  // Monitor: every write must match the oldest expected word.
  always @(negedge clk) begin
    exp_t e;
    if (o_we === 1'b1) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_write: got addr %h data %h expected none",
                 o_addr, o_data);
      end else begin
        e = sb.pop_front();
        chk("wdata",  o_data,                e.data);
        chk("waddr",  {24'b0, o_addr},       {24'b0, e.addr});
        chk("wcount", {25'b0, o_word_count}, {25'b0, e.cnt});
      end
    end
  end

  initial begin
    int r;
    logic [7:0] b;
    i_rst      = 1'b1;
    i_start    = 1'b0;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we",    {31'b0, o_we},         32'd0);
    chk("rst_data",  o_data,                32'd0);
    chk("rst_addr",  {24'b0, o_addr},       32'd0);
    chk("rst_busy",  {31'b0, o_busy},       32'd0);
    chk("rst_done",  {31'b0, o_done},       32'd0);
    chk("rst_ovf",   {31'b0, o_overflow},   32'd0);
    chk("rst_count", {25'b0, o_word_count}, 32'd0);
    i_rst = 1'b0;
    idle(2);

    // First word, then two more and a halt word.
    step(1'b1, 1'b0, 8'h00);
    send_word(32'h20010005, 0);
    idle(2);
    status("word0");
    send_word(rand_word(), 1);
    send_word(rand_word(), 0);
    send_word(32'hFFFFFFFF, 0);
    idle(2);
    status("halt");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'($urandom));
    idle(2);
    status("done_ignore");

    // Restart from DONE; byte in the WRITE cycle; start mid-word ignored.
    step(1'b1, 1'b0, 8'h00);
    status("restart");
    step(1'b0, 1'b1, 8'hAA);
    step(1'b0, 1'b1, 8'hBB);
    step(1'b0, 1'b1, 8'hCC);
    step(1'b0, 1'b1, 8'hDD);
    step(1'b0, 1'b1, 8'h11);
    step(1'b1, 1'b1, 8'h22);
    step(1'b0, 1'b1, 8'h33);
    step(1'b0, 1'b1, 8'h44);
    idle(2);
    status("back2back");
    send_word(32'hFFFFFFFF, 0);
    idle(2);

    // Fill all 64 slots without a halt word.
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 64; i++) send_word(rand_word(), (i % 3 == 0) ? 2 : 0);
    idle(2);
    status("full");
    step(1'b0, 1'b1, 8'h12);
    idle(2);

    // Asynchronous reset in the middle of a word.
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h5A);
    step(1'b0, 1'b1, 8'hA5);
    #2;
    i_rst = 1'b1;
    #1;
    model_reset();
    chk("arst_we",    {31'b0, o_we},         32'd0);
    chk("arst_addr",  {24'b0, o_addr},       32'd0);
    chk("arst_data",  o_data,                32'd0);
    chk("arst_busy",  {31'b0, o_busy},       32'd0);
    chk("arst_count", {25'b0, o_word_count}, 32'd0);
    chk("arst_sb",    32'(sb.size()),        32'd0);
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    idle(1);
    step(1'b1, 1'b0, 8'h00);
    send_word(32'h01020304, 0);
    idle(2);
    status("post_rst");

    // Random streams with random starts, gaps and frequent FF bytes.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      b = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      step(r == 0, r >= 4, b);
    end
    idle(2);
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'hFF);
    idle(3);
    status("rand_end");
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/imem_byte_loader.md
Name: imem_byte_loader

Overview:
- Write-side companion to the byte-addressable instruction memory.
- Takes a serial byte stream from the UART receiver.
- Assembles each group of four bytes into a 32-bit word, most significant byte first.
- Writes each word into the memory through its single write port, in order from the bottom of memory, until a halt word is written or memory is full.

Parameters:
- NB_DATA, 32, word width; fixed at 32; the block assumes exactly 4 bytes per word.
- NB_ADDR, 8, memory byte-address width; memory holds 2**NB_ADDR bytes.
- HALT_WORD, 32'hFFFFFFFF, word that terminates a load; it is itself written.

Ports:
- clk  input  1  system clock, rising edge.
- i_rst  input  1  asynchronous active-high reset.
- i_start  input  1  one-cycle pulse; begins a new load at word 0. Honoured only in IDLE or DONE.
- i_rx_data  input  8  received byte.
- i_rx_valid  input  1  one-cycle strobe qualifying i_rx_data. There is no backpressure.
- o_we  output  1  memory write enable, one cycle per word.
- o_data  output  NB_DATA  assembled word; valid while o_we=1.
- o_addr  output  NB_ADDR  end-exclusive byte address (word base + 4). The memory stores bytes at o_addr-4 .. o_addr-1.
- o_busy  output  1  high in COLLECT and WRITE.
- o_done  output  1  high in DONE; held until the next i_start or reset.
- o_overflow  output  1  valid in DONE; 1 = memory filled without seeing HALT_WORD.
- o_word_count  output  NB_ADDR-1  number of words written in the current or most recent load.

Behaviour:
- Reset (asynchronous, i_rst=1):
  - State goes to IDLE; byte counter, word base and word count are cleared to 0.
  - o_we=0, o_data=0, o_addr=0, o_busy=0, o_done=0, o_overflow=0, o_word_count=0.
  - Reset mid-load discards any partial word. Nothing is written on the reset edge.
- State machine:
  - IDLE: i_start -> COLLECT. Clears the word base, byte counter, word count and o_overflow.
  - COLLECT: each i_rx_valid shifts the byte into the assembly register at byte lane 3 - byte_cnt (first byte goes to [31:24]), then increments byte_cnt (2-bit). When the 4th byte is captured -> WRITE on the next edge.
  - WRITE: exactly one cycle.
    - o_we=1, o_data=assembled word, o_addr=word_base+4 (mod 2**NB_ADDR).
    - o_word_count increments on the exit edge; word_base advances by 4.
    - If the word equals HALT_WORD -> DONE with o_overflow=0.
    - Else if word_base was 2**NB_ADDR-4 (last slot) -> DONE with o_overflow=1.
    - Else -> COLLECT.
  - DONE: o_done=1. i_rx_valid is ignored. i_start -> COLLECT (same clears as from IDLE; o_done drops the next cycle).
- Latency: o_we rises on the cycle after the clock edge that captured the 4th byte.
- Byte arriving during WRITE: it is captured as byte 0 of the next word and byte_cnt becomes 1, unless WRITE exits to DONE, in which case the byte is dropped.
- i_start while in COLLECT or WRITE is ignored.
- Address wrap: for the last slot (base 2**NB_ADDR-4), o_addr = 0. This is the correct end-exclusive encoding, not an error.
- o_data and o_addr are registered and hold their last values outside WRITE; only o_we qualifies them.
- Bytes are never written partially; a load that stops mid-word leaves memory untouched for that word.

Test Plan:
- Reset then i_start, bytes 8'h20,8'h01,8'h00,8'h05 -> one o_we pulse, o_data=32'h20010005, o_addr=8'h04, o_word_count=1, state back to COLLECT.
- Three words then FF,FF,FF,FF -> four o_we pulses at o_addr 04,08,0C,10; last o_data=32'hFFFFFFFF; o_done=1, o_overflow=0, o_word_count=4; later bytes produce no o_we.
- 64 non-halt words, NB_ADDR=8 -> 64th write at o_addr=8'h00; o_done=1, o_overflow=1, o_word_count=64.
- A byte strobed in the WRITE cycle of word 0 (bytes AA,BB,CC,DD then 11 immediately, then 22,33,44) -> word 1 = 32'h11223344 at o_addr=8'h08.
- Assert i_rst after 2 bytes of a word -> all outputs 0 immediately (asynchronous); after i_start, the next 4 bytes form word 0 at o_addr=8'h04.
- i_start pulsed mid-COLLECT -> ignored, byte assembly continues. i_start in DONE -> o_done drops, o_word_count restarts, and the next write is at o_addr=8'h04.
